alu_muldiv: RTL and testbench

- Parametrised next-generation execute unit for the scpu datapath.
- Performs the RV32I/RV64I integer ALU ops plus the RV-M multiply/divide ops, over a valid/ready issue handshake.
- Base ops complete in 1 cycle. MUL*/DIV*/REM* run on an iterative radix-2 engine taking XLEN cycles.
- Sits between the decode/operand-select stage and writeback. Control stalls the pipe while in_ready is low.

---
 rtl/alu_muldiv.sv | 260 ++++++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// RV32/RV64 I+M execute unit: single-cycle base ALU plus an iterative radix-2
// multiply/divide engine, behind a valid/ready issue handshake.
module alu_muldiv #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] res,
  output logic            zero,
  output logic            busy
);

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;
  logic [XLEN-1:0]   r_res;
  logic              r_zero;
  logic [4:0]        r_op;
  logic              r_neg;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_opnd;
  logic [SHW-1:0]    r_count;

  logic              w_accept;
  logic              w_is_mul;
  logic              w_is_div;
  logic              w_is_m;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_fast;
  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_base_res;
  logic [XLEN-1:0]   w_fast_res;
  logic              w_r_is_mul;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_hi_nx;
  logic [XLEN-1:0]   w_lo_nx;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_final;
  logic [XLEN-1:0]   w_res_nx;

  // Flush in IDLE blocks acceptance even when in_valid is high.
  assign w_accept = in_valid & r_in_ready & ~flush;

  // ---------------------------------------------------------------------------
  // Issue-side decode, operand magnitudes and fast-path detection
  // ---------------------------------------------------------------------------
  assign w_is_mul   = (op == OP_MUL) | (op == OP_MULH) | (op == OP_MULHSU) | (op == OP_MULHU);
  assign w_is_div   = (op == OP_DIV) | (op == OP_DIVU) | (op == OP_REM) | (op == OP_REMU);
  assign w_is_m     = w_is_mul | w_is_div;
  assign w_a_signed = (op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM);
  assign w_b_signed = (op == OP_MULH) | (op == OP_DIV) | (op == OP_REM);
  assign w_a_neg    = w_a_signed & a[XLEN-1];
  assign w_b_neg    = w_b_signed & b[XLEN-1];
  assign w_a_mag    = w_a_neg ? ('0 - a) : a;
  assign w_b_mag    = w_b_neg ? ('0 - b) : b;
  assign w_div_zero = w_is_div & (b == '0);
  assign w_div_ovf  = ((op == OP_DIV) | (op == OP_REM)) & (a == MOST_NEG) & (b == '1);
  assign w_fast     = w_div_zero | w_div_ovf;
  assign w_shamt    = b[SHW-1:0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_base_res = '0;
    case (op)
      OP_ADD:  w_base_res = a + b;
      OP_SUB:  w_base_res = a - b;
      OP_SLL:  w_base_res = a << w_shamt;
      OP_SLT:  w_base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_base_res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  w_base_res = a ^ b;
      OP_SRL:  w_base_res = a >> w_shamt;
      OP_SRA:  w_base_res = XLEN'($signed(a) >>> w_shamt);
      OP_OR:   w_base_res = a | b;
      OP_AND:  w_base_res = a & b;
      default: w_base_res = '0;
    endcase
  end

  always_comb begin
    w_fast_res = '0;
    if (w_div_zero) begin
      w_fast_res = ((op == OP_DIV) | (op == OP_DIVU)) ? '1 : a;
    end else if (w_div_ovf) begin
      w_fast_res = (op == OP_DIV) ? a : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  // Multiply keeps {r_hi, r_lo} as the growing product with the multiplier in
  // r_lo; divide keeps the partial remainder in r_hi and the dividend/quotient
  // shifting through r_lo.
  // ---------------------------------------------------------------------------
  assign w_r_is_mul = (r_op == OP_MUL) | (r_op == OP_MULH) |
                      (r_op == OP_MULHSU) | (r_op == OP_MULHU);
  assign w_sum      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_rem_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_opnd};
  assign w_ge       = ~w_diff[XLEN];

  always_comb begin
    if (w_r_is_mul) begin
      w_hi_nx = w_sum[XLEN:1];
      w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
    end else begin
      w_hi_nx = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
      w_lo_nx = {r_lo[XLEN-2:0], w_ge};
    end
  end

  // Sign fix-up is applied only once, on the step that completes the engine.
  assign w_prod     = {w_hi_nx, w_lo_nx};
  assign w_prod_fix = r_neg ? ('0 - w_prod) : w_prod;

  always_comb begin
    w_final = '0;
    case (r_op)
      OP_MUL:                         w_final = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   w_final = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                w_final = r_neg ? ('0 - w_lo_nx) : w_lo_nx;
      OP_REM, OP_REMU:                w_final = r_neg ? ('0 - w_hi_nx) : w_hi_nx;
      default:                        w_final = '0;
    endcase
  end

  assign w_res_nx = (r_state == S_BUSY) ? w_final :
                    (w_is_m ? w_fast_res : w_base_res);

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_res       <= '0;
      r_zero      <= 1'b1;
      r_op        <= '0;
      r_neg       <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opnd      <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op       <= op;
            r_in_ready <= 1'b0;
            if (w_is_m && !w_fast) begin
              r_state <= S_BUSY;
              r_busy  <= 1'b1;
              r_neg   <= (op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
              r_hi    <= '0;
              r_lo    <= w_a_mag;
              r_opnd  <= w_b_mag;
              r_count <= SHW'(XLEN - 1);
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_res       <= w_res_nx;
              r_zero      <= (w_res_nx == '0);
            end
          end
        end
        S_BUSY: begin
          if (flush) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
          end else begin
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
            r_count <= r_count - 1'b1;
            if (r_count == '0) begin
              r_state     <= S_DONE;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
              r_res       <= w_res_nx;
              r_zero      <= (w_res_nx == '0);
            end
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // A flush arriving during the DONE cycle still suppresses the result pulse.
  assign out_valid = r_out_valid & ~flush;
  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign res       = r_res;
  assign zero      = r_zero;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: directed vectors on a 32-bit and a 64-bit
// instance, with a per-instance monitor checking result, zero and latency.
module tb_alu_muldiv;

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd2, SLT = 5'd3, SLTU = 5'd4;
  localparam logic [4:0] XOR = 5'd5, SRL = 5'd6, SRA = 5'd7, OR = 5'd8, AND = 5'd9;
  localparam logic [4:0] MUL = 5'd10, MULH = 5'd11, MULHSU = 5'd12, MULHU = 5'd13;
  localparam logic [4:0] DIV = 5'd14, DIVU = 5'd15, REM = 5'd16, REMU = 5'd17;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        v32 = 1'b0, rdy32, ov32, z32, bsy32;
  logic [4:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0, r32;
  logic        v64 = 1'b0, rdy64, ov64, z64, bsy64;
  logic [4:0]  op64 = '0;
  logic [63:0] a64 = '0, b64 = '0, r64;

  exp_t q32[$];
  exp_t q64[$];
  int   cnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  alu_muldiv #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .op(op32),
    .a(a32), .b(b32), .flush(flush), .out_valid(ov32), .res(r32),
    .zero(z32), .busy(bsy32)
  );

  alu_muldiv #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64), .op(op64),
    .a(a64), .b(b64), .flush(1'b0), .out_valid(ov64), .res(r64),
    .zero(z64), .busy(bsy64)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Issue one op when the unit is ready; optionally push its expected result.
  task automatic issue(input bit w64, input logic [4:0] o, input logic [63:0] x,
                       input logic [63:0] y, input logic [63:0] e, input int lat,
                       input string nm, input bit push);
    int   guard;
    exp_t ent;
    guard = 0;
    @(negedge clk);
    while (!(w64 ? rdy64 : rdy32) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      n_checks++;
      $display("FAIL %s_ready: in_ready never rose within 500 cycles", nm);
    end
    if (w64) begin
      v64 = 1'b1; op64 = o; a64 = x; b64 = y;
    end else begin
      v32 = 1'b1; op32 = o; a32 = x[31:0]; b32 = y[31:0];
    end
    if (push) begin
      ent.res = e; ent.lat = lat; ent.acc = cnt + 1; ent.nm = nm;
      if (w64) q64.push_back(ent);
      else q32.push_back(ent);
    end
    @(posedge clk);
    #1;
    v32 = 1'b0; v64 = 1'b0;
    op32 = 5'($urandom); a32 = $urandom; b32 = $urandom;
    op64 = 5'($urandom); a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov32) begin
      if (q32.size() == 0) check("spurious_out_valid32", 64'(ov32), 64'd0);
      else begin
        e = q32.pop_front();
        check({e.nm, "_res"}, 64'(r32), e.res);
        check({e.nm, "_zero"}, 64'(z32), 64'(e.res == 64'd0));
        check({e.nm, "_lat"}, 64'(cnt - e.acc + 1), 64'(e.lat));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov64) begin
      if (q64.size() == 0) check("spurious_out_valid64", 64'(ov64), 64'd0);
      else begin
        e = q64.pop_front();
        check({e.nm, "_res"}, r64, e.res);
        check({e.nm, "_zero"}, 64'(z64), 64'(e.res == 64'd0));
        check({e.nm, "_lat"}, 64'(cnt - e.acc + 1), 64'(e.lat));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int guard;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(rdy32), 64'd1);
    check("rst_out_valid", 64'(ov32), 64'd0);
    check("rst_busy", 64'(bsy32), 64'd0);
    check("rst_res", 64'(r32), 64'd0);
    check("rst_zero", 64'(z32), 64'd1);
    rst = 1'b0;

    // Base ALU ops, one cycle.
    issue(0, ADD,  64'h7FFF_FFFF, 64'h1,         64'h8000_0000, 1, "add_ovf", 1);
    issue(0, SUB,  64'h5,         64'h5,         64'h0,         1, "sub_zero", 1);
    issue(0, SRA,  64'h8000_0000, 64'h21,        64'hC000_0000, 1, "sra", 1);
    issue(0, SLT,  64'hFFFF_FFFF, 64'h1,         64'h1,         1, "slt", 1);
    issue(0, SLTU, 64'hFFFF_FFFF, 64'h1,         64'h0,         1, "sltu", 1);
    issue(0, SLL,  64'h0000_0003, 64'h24,        64'h30,        1, "sll", 1);
    issue(0, SRL,  64'h8000_0000, 64'h1F,        64'h1,         1, "srl", 1);
    issue(0, XOR,  64'hF0F0_F0F0, 64'hFF00_FF00, 64'h0FF0_0FF0, 1, "xor", 1);
    issue(0, OR,   64'hF0F0_0000, 64'h0000_0F0F, 64'hF0F0_0F0F, 1, "or", 1);
    issue(0, AND,  64'hF0F0_F0F0, 64'hFF00_FF00, 64'hF000_F000, 1, "and", 1);
    issue(0, 5'd20, 64'h1234,     64'h5678,      64'h0,         1, "reserved", 1);

    // Multiply, with the busy window checked on the first one.
    issue(0, MUL, 64'hFFFF_FFFD, 64'h7, 64'hFFFF_FFEB, 33, "mul", 1);
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (rdy32 !== 1'b0 || bsy32 !== 1'b1) ok = 1'b0;
    end
    check("mul_busy_window", 64'(ok), 64'd1);
    issue(0, MULH,   64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 33, "mulh", 1);
    issue(0, MULHSU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 33, "mulhsu", 1);
    issue(0, MULHU,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 33, "mulhu", 1);

    // Divide.
    issue(0, DIV,  64'hFFFF_FFF9, 64'h2,  64'hFFFF_FFFD, 33, "div", 1);
    issue(0, REM,  64'hFFFF_FFF9, 64'h2,  64'hFFFF_FFFF, 33, "rem", 1);
    issue(0, DIVU, 64'hFFFF_FFFE, 64'h10, 64'h0FFF_FFFF, 33, "divu", 1);
    issue(0, REMU, 64'd100,       64'd7,  64'h2,         33, "remu", 1);

    // Fast path.
    issue(0, DIV,  64'h9,         64'h0,         64'hFFFF_FFFF, 1, "div_by0", 1);
    issue(0, DIVU, 64'h9,         64'h0,         64'hFFFF_FFFF, 1, "divu_by0", 1);
    issue(0, REMU, 64'h9,         64'h0,         64'h9,         1, "remu_by0", 1);
    issue(0, REM,  64'h9,         64'h0,         64'h9,         1, "rem_by0", 1);
    issue(0, DIV,  64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1, "div_ovf", 1);
    issue(0, REM,  64'h8000_0000, 64'hFFFF_FFFF, 64'h0,         1, "rem_ovf", 1);

    // Flush mid-divide: no result, ready the cycle after the flush edge.
    issue(0, DIV, 64'd1000, 64'd3, 64'h0, 0, "div_flushed", 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 64'(rdy32), 64'd1);
    check("flush_busy", 64'(bsy32), 64'd0);
    repeat (40) @(negedge clk);

    // Flush together with in_valid in IDLE: nothing accepted.
    v32 = 1'b1; op32 = ADD; a32 = 32'd1; b32 = 32'd1; flush = 1'b1;
    @(posedge clk);
    #1 begin v32 = 1'b0; flush = 1'b0; end
    @(negedge clk);
    check("flush_vs_issue_ready", 64'(rdy32), 64'd1);

    // Reset mid-multiply, then recover with an ADD.
    issue(0, MUL, 64'd12345, 64'd678, 64'h0, 0, "mul_reset", 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_res", 64'(r32), 64'd0);
    check("midrst_out_valid", 64'(ov32), 64'd0);
    check("midrst_busy", 64'(bsy32), 64'd0);
    check("midrst_in_ready", 64'(rdy32), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    issue(0, ADD, 64'd2, 64'd3, 64'd5, 1, "add_after_rst", 1);

    // 64-bit instance.
    issue(1, MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu64", 1);
    issue(1, SLL, 64'h1, 64'h41, 64'h2, 1, "sll64", 1);
    issue(1, DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65, "div64", 1);

    guard = 0;
    while ((q32.size() != 0 || q64.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("q32_drained", 64'(q32.size()), 64'd0);
    check("q64_drained", 64'(q64.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
